ram_port_arbiter: RTL
=====================

// Module: ram_port_arbiter
// PURPOSE
//  Shares the single RAM port among all cache requesters (I/D caches of both cores).
//  Sits between the cache side and the RAM model, under memory_control's coherence sequencing.
//  Grants one requester per RAM access: data before instruction, round-robin within each class,
//  with a starvation override. Holds the grant until the access completes.
// PARAMETERS
//  NREQ          4   number of requesters; index 0=I0, 1=D0, 2=I1, 3=D1 (odd index = data)
//  STARVE_LIMIT  8   lost arbitrations before a pending instruction requester is forced to win
// PORTS
//  CLK         in   1          clock, rising edge
//  RST         in   1          asynchronous, active-high reset
//  req_ren     in   NREQ       read request per requester
//  req_wen     in   NREQ       write request per requester (data requesters only; ignored on even idx)
//  req_addr    in   NREQx32    word address per requester
//  req_store   in   NREQx32    write data per requester
//  req_wait    out  NREQ       1 = stall; 0 for exactly the completing cycle of the granted requester
//  req_load    out  32         ramload broadcast; valid only while req_wait[grant_id]==0
//  ramREN      out  1          RAM read enable
//  ramWEN      out  1          RAM write enable
//  ramaddr     out  32         RAM address
//  ramstore    out  32         RAM write data
//  ramload     in   32         RAM read data
//  ramstate    in   ramstate_t FREE/BUSY/ACCESS/ERROR
//  grant_id    out  2          registered index of current owner (valid when busy)
//  busy        out  1          1 while in ISSUE
// BEHAVIOUR
//  Reset: state=IDLE, grant_id=0, rr_d=0, rr_i=0, starve cnts=0; busy=0, ramREN=ramWEN=0,
//   ramaddr=ramstore=0, req_wait='1, req_load=0.
//  Request valid: pend[k] = req_ren[k] | req_wen[k]. If both set, it is a write.
//  States:
//   IDLE:    RAM outputs 0, all waits 1. If any pend: register winner in grant_id -> ISSUE.
//   ISSUE:   drive ramaddr/ramstore/ramREN/ramWEN from grant_id. ramstate==ACCESS:
//            req_wait[grant_id]=0, req_load=ramload -> RELEASE. BUSY/FREE/ERROR: hold, wait=1.
//            If pend[grant_id] drops before ACCESS: abort -> IDLE, pointers/counters unchanged.
//   RELEASE: RAM outputs 0, all waits 1 for one cycle (requester updates addr); update
//            pointers/counters -> IDLE.
//  Latency: request to first ramREN/ramWEN = 1 cycle; min turnaround = RAM latency + 2 cycles.
//  Winner selection (combinational in IDLE, evaluated on pend):
//   1) any even k with starve[k]==STARVE_LIMIT: lowest such k wins.
//   2) else any odd k pending: round-robin from rr_d (first pending odd idx >= rr_d, wrapping).
//   3) else even requesters round-robin from rr_i.
//  RELEASE updates: rr_d or rr_i (by winner class) = (grant_id+2) mod NREQ, wrapping over its class;
//   each pending even requester that did not win: starve++ saturating at STARVE_LIMIT;
//   winner's starve cleared. Non-pending requesters' starve cleared.
//  Inputs changing while granted: address/data sampled combinationally every cycle (requester
//   must hold stable until its wait drops). Other requesters' inputs ignored until IDLE.
//  Reset mid-ISSUE: immediate return to IDLE, RAM enables drop asynchronously; no completion.
//  ramstate==ACCESS in IDLE/RELEASE ignored.
// STRUCTURE
//  cpu_types_pkg: add arb_state_t {IDLE, ISSUE, RELEASE} and REQ_I0/REQ_D0/REQ_I1/REQ_D1
//   constants; reuse existing word_t, ramstate_t.
//  Sub-module rr_pick (combinational): pend vector + start pointer -> winner idx + found flag;
//   instantiated twice (data class, instruction class).
// TESTING
//  T1 reset: RST=1 mid-ISSUE -> next sample ramREN=ramWEN=0, req_wait=4'b1111, busy=0, grant_id=0.
//  T2 single read: req_ren[0]=1 addr 0x40, RAM ACCESS after 3 cycles -> ramREN cycle 1, req_wait[0]=0
//     one cycle with req_load=ramload, RELEASE, IDLE.
//  T3 data priority: req_ren=4'b0101, req_wen[1]=1 same cycle -> grant_id=1, ramWEN=1, ramstore=dstore[1].
//  T4 round-robin: D0 and D1 continuously pending -> grants alternate 1,3,1,3 over 4 accesses.
//  T5 starvation: I1 pending with D0 always pending, STARVE_LIMIT=8 -> I1 granted on 9th arbitration.
//  T6 abort: grant D1, drop req_ren[3] while ramstate=BUSY -> IDLE next cycle, rr_d unchanged,
//     no req_wait pulse.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: RAM word, RAM handshake state and RAM-port arbiter definitions.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef logic [1:0] arb_state_t;
  localparam arb_state_t IDLE    = 2'd0;
  localparam arb_state_t ISSUE   = 2'd1;
  localparam arb_state_t RELEASE = 2'd2;

  localparam int REQ_I0 = 0;
  localparam int REQ_D0 = 1;
  localparam int REQ_I1 = 2;
  localparam int REQ_D1 = 3;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set bit of pend at or after start, wrapping (NREQ must be a power of two).
module rr_pick #(
  parameter int NREQ = 4,
  parameter int GW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] pend,
  input  logic [GW-1:0]   start,
  output logic [GW-1:0]   idx,
  output logic            found
);

  logic [GW-1:0] k;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    k     = '0;
    for (int i = 0; i < NREQ; i++) begin
      k = start + GW'(i);
      if (!found && pend[k]) begin
        found = 1'b1;
        idx   = k;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Single RAM port shared by all cache requesters: data before instruction, round-robin per class,
// starvation override for instruction fetches; grant is held until the RAM access completes.
module ram_port_arbiter
  import cpu_types_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       req_ren,
  input  logic [NREQ-1:0]       req_wen,
  input  word_t [NREQ-1:0]      req_addr,
  input  word_t [NREQ-1:0]      req_store,
  output logic [NREQ-1:0]       req_wait,
  output word_t                 req_load,
  output logic                  ramREN,
  output logic                  ramWEN,
  output word_t                 ramaddr,
  output word_t                 ramstore,
  input  word_t                 ramload,
  input  ramstate_t             ramstate,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                  busy
);

  localparam int GW = $clog2(NREQ);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  arb_state_t    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] rr_dat_q, rr_dat_d;
  logic [GW-1:0] rr_ins_q, rr_ins_d;
  logic [SW-1:0] starve_q [NREQ];
  logic [SW-1:0] starve_d [NREQ];

  logic [NREQ-1:0] pend, pend_dat, pend_ins;
  logic [GW-1:0]   dat_idx, ins_idx, starve_idx, winner;
  logic            dat_found, ins_found, starve_hit;

  // Write enables only mean something on odd (data) requesters.
  always_comb begin
    pend     = '0;
    pend_dat = '0;
    pend_ins = '0;
    for (int k = 0; k < NREQ; k++) begin
      if ((k % 2) == 1) begin
        pend[k]     = req_ren[k] | req_wen[k];
        pend_dat[k] = pend[k];
      end else begin
        pend[k]     = req_ren[k];
        pend_ins[k] = pend[k];
      end
    end
  end

  rr_pick #(.NREQ(NREQ), .GW(GW)) u_pick_dat (
    .pend  (pend_dat),
    .start (rr_dat_q),
    .idx   (dat_idx),
    .found (dat_found)
  );

  rr_pick #(.NREQ(NREQ), .GW(GW)) u_pick_ins (
    .pend  (pend_ins),
    .start (rr_ins_q),
    .idx   (ins_idx),
    .found (ins_found)
  );

  // Descending scan so the lowest starved instruction requester ends up selected.
  always_comb begin
    starve_hit = 1'b0;
    starve_idx = '0;
    for (int k = NREQ - 2; k >= 0; k -= 2) begin
      if (pend[k] && starve_q[k] == SW'(STARVE_LIMIT)) begin
        starve_hit = 1'b1;
        starve_idx = GW'(k);
      end
    end
    if (starve_hit)
      winner = starve_idx;
    else if (dat_found)
      winner = dat_idx;
    else
      winner = ins_idx;
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_dat_d = rr_dat_q;
    rr_ins_d = rr_ins_q;
    starve_d = starve_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    req_wait = '1;
    req_load = '0;
    case (state_q)
      IDLE: begin
        if (|pend) begin
          grant_d = winner;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        ramaddr  = req_addr[grant_q];
        ramstore = req_store[grant_q];
        ramWEN   = grant_q[0] & req_wen[grant_q];
        ramREN   = req_ren[grant_q] & ~ramWEN;
        if (!pend[grant_q]) begin
          state_d = IDLE;
        end else if (ramstate == ACCESS) begin
          req_wait[grant_q] = 1'b0;
          req_load          = ramload;
          state_d           = RELEASE;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        if (grant_q[0])
          rr_dat_d = grant_q + GW'(2);
        else
          rr_ins_d = grant_q + GW'(2);
        for (int k = 0; k < NREQ; k += 2) begin
          if (GW'(k) == grant_q || !pend[k])
            starve_d[k] = '0;
          else if (starve_q[k] != SW'(STARVE_LIMIT))
            starve_d[k] = starve_q[k] + SW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_dat_q <= '0;
      rr_ins_q <= '0;
      for (int k = 0; k < NREQ; k++) starve_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_dat_q <= rr_dat_d;
      rr_ins_q <= rr_ins_d;
      starve_q <= starve_d;
    end
  end

  assign grant_id = grant_q;
  assign busy     = (state_q == ISSUE);

endmodule
